dcache_controller: RTL



---
 rtl/dcache_controller.sv | 98 +++++++++
 1 files changed

// File: rtl/dcache_controller.sv
// dcache_controller: 2-way data cache sequencer with hit detection, word merge,
// dirty LRU write-back and line refill between CPU port, cache SRAM and memory.
module dcache_controller (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         cpu_req_i,
   input  logic         cpu_write_i,
   input  logic [31:0]  cpu_addr_i,
   input  logic [31:0]  cpu_data_i,
   output logic [31:0]  cpu_data_o,
   output logic         cpu_stall_o,
   output logic [3:0]   sram_addr_o,
   output logic [24:0]  sram_tag_o,
   output logic [255:0] sram_data_o,
   output logic         sram_enable_o,
   output logic         sram_write_o,
   input  logic [24:0]  sram_tag_i,
   input  logic [255:0] sram_data_i,
   input  logic         sram_hit_i,
   output logic         mem_enable_o,
   output logic         mem_write_o,
   output logic [31:0]  mem_addr_o,
   output logic [255:0] mem_data_o,
   input  logic [255:0] mem_data_i,
   input  logic         mem_ack_i
);
   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, UPDATE} state_t;
   state_t state_q, state_d;
   logic mem_enable_q, mem_enable_d, mem_write_q, mem_write_d, dirty, miss;
   logic [31:0] mem_addr_q, mem_addr_d, refill_addr;
   logic [255:0] mem_data_q, mem_data_d, line_q, line_d, base, merged;
   logic [2:0] w;
   logic unused_ok;
   assign unused_ok = ^cpu_addr_i[1:0];
   assign w = cpu_addr_i[4:2];
   assign refill_addr = {cpu_addr_i[31:5], 5'b0};
   assign dirty = sram_tag_i[24] & sram_tag_i[23];
   assign miss = (state_q == IDLE) & cpu_req_i & ~sram_hit_i;
   assign cpu_data_o = sram_data_i[32*w +: 32];
   assign cpu_stall_o = (state_q != IDLE) | (cpu_req_i & ~sram_hit_i);
   assign sram_addr_o = cpu_addr_i[8:5];
   assign sram_tag_o = {1'b1, cpu_write_i, cpu_addr_i[31:9]};
   assign sram_enable_o = cpu_req_i | (state_q != IDLE);
   assign sram_write_o = (state_q == UPDATE) | ((state_q == IDLE) & cpu_req_i & sram_hit_i & cpu_write_i);
   assign mem_enable_o = mem_enable_q;
   assign mem_write_o = mem_write_q;
   assign mem_addr_o = mem_addr_q;
   assign mem_data_o = mem_data_q;
   // UPDATE writes the captured refill line; a hit rewrites the SRAM line in place
   always_comb begin
      base = (state_q == UPDATE) ? line_q : sram_data_i;
      merged = base;
      merged[32*w +: 32] = cpu_data_i;
      sram_data_o = cpu_write_i ? merged : base;
   end
   always_comb begin
      state_d = state_q;
      mem_enable_d = mem_enable_q;
      mem_write_d = mem_write_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      line_d = line_q;
      if (miss) begin
         state_d = dirty ? WRITEBACK : REFILL;
         mem_enable_d = 1'b1;
         mem_write_d = dirty;
         mem_addr_d = dirty ? {sram_tag_i[22:0], cpu_addr_i[8:5], 5'b0} : refill_addr;
         mem_data_d = dirty ? sram_data_i : mem_data_q;
      end else if (state_q == WRITEBACK && mem_ack_i) begin
         state_d = REFILL;
         mem_write_d = 1'b0;
         mem_addr_d = refill_addr;
      end else if (state_q == REFILL && mem_ack_i) begin
         state_d = UPDATE;
         mem_enable_d = 1'b0;
         line_d = mem_data_i;
      end else if (state_q == UPDATE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         mem_enable_q <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         line_q <= '0;
      end else begin
         state_q <= state_d;
         mem_enable_q <= mem_enable_d;
         mem_write_q <= mem_write_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         line_q <= line_d;
      end
   end
endmodule
